// File: rtl/rmii_rx.sv
// rmii_rx: RMII receive path; hunts preamble/SFD and assembles LSB-first dibits into bytes.
// Define RMII_RX_PREAMBLE_EMIT_EN to also emit each full 0x55 preamble byte.
module rmii_rx (
  input  logic       clk,
  input  logic       resetn,
  input  logic       crs_dv,
  input  logic [1:0] rxd,
  output logic [7:0] received_byte,
  output logic       byte_valid,
  output logic       data_valid,
  output logic       frame_error
);

  typedef enum logic [1:0] {
    IDLE,
    HUNT,
    RECEIVE
  } state_t;

  state_t     r_state, w_state;
  logic       r_crs0, r_crs1, r_armed;
  logic [1:0] r_rxd0, r_rxd1;
  logic [2:0] r_pre, w_pre;
  logic [1:0] r_ph, w_ph;
  logic [5:0] r_sh, w_sh;
  logic       r_pend, w_pend;
  logic [7:0] r_byte, w_byte;
  logic       r_bv, w_bv;
  logic       r_dv, w_dv;
  logic       r_fe, w_fe;
  logic       w_end;
  logic [7:0] w_asm;

  // Dibit in r_rxd1 is live if crs_dv was high when it or its successor was sampled.
  assign w_end = ~(r_crs1 | r_crs0);
  assign w_asm = {r_rxd1, r_sh};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_crs0  <= 1'b0;
      r_crs1  <= 1'b0;
      r_rxd0  <= 2'd0;
      r_rxd1  <= 2'd0;
      r_armed <= 1'b0;
      r_state <= IDLE;
      r_pre   <= 3'd0;
      r_ph    <= 2'd0;
      r_sh    <= 6'd0;
      r_pend  <= 1'b0;
      r_byte  <= 8'h00;
      r_bv    <= 1'b0;
      r_dv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_crs0  <= crs_dv;
      r_crs1  <= r_crs0;
      r_rxd0  <= rxd;
      r_rxd1  <= r_rxd0;
      r_armed <= r_armed | ~crs_dv;
      r_state <= w_state;
      r_pre   <= w_pre;
      r_ph    <= w_ph;
      r_sh    <= w_sh;
      r_pend  <= w_pend;
      r_byte  <= w_byte;
      r_bv    <= w_bv;
      r_dv    <= w_dv;
      r_fe    <= w_fe;
    end
  end

  always_comb begin
    w_state = r_state;
    w_pre   = r_pre;
    w_ph    = r_ph;
    w_sh    = r_sh;
    w_pend  = r_pend;
    w_byte  = r_byte;
    w_bv    = 1'b0;
    w_dv    = r_dv;
    w_fe    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_pre  = 3'd0;
        w_ph   = 2'd0;
        w_pend = 1'b0;
        if (r_armed && r_crs0)
          w_state = HUNT;
      end
      HUNT: begin
        if (w_end) begin
          w_state = IDLE;
          w_fe    = r_dv;
          w_dv    = 1'b0;
        end else begin
          unique case (r_rxd1)
            2'b01: begin
              w_pre = (r_pre == 3'd7) ? 3'd4 : r_pre + 3'd1;
`ifdef RMII_RX_PREAMBLE_EMIT_EN
              if (r_pre[1:0] == 2'd3) begin
                w_byte = 8'h55;
                w_bv   = 1'b1;
                w_dv   = 1'b1;
              end
`endif
            end
            2'b11: begin
              if (r_pre != 3'd0) begin
                w_state = RECEIVE;
                w_ph    = 2'd0;
                w_dv    = 1'b1;
                // A preamble byte just went out: push 0xD5 one cycle later.
                if (r_bv) begin
                  w_pend = 1'b1;
                end else begin
                  w_byte = 8'hD5;
                  w_bv   = 1'b1;
                end
              end else begin
                w_pre = 3'd0;
              end
            end
            default: w_pre = 3'd0;
          endcase
        end
      end
      RECEIVE: begin
        if (w_end) begin
          w_state = IDLE;
          w_dv    = 1'b0;
          w_fe    = (r_ph != 2'd0);
          w_pend  = 1'b0;
        end else begin
          w_sh = w_asm[7:2];
          w_ph = r_ph + 2'd1;
          if (r_pend) begin
            w_byte = 8'hD5;
            w_bv   = 1'b1;
            w_pend = 1'b0;
          end
          if (r_ph == 2'd3) begin
            w_byte = w_asm;
            w_bv   = 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign received_byte = r_byte;
  assign byte_valid    = r_bv;
  assign data_valid    = r_dv;
  assign frame_error   = r_fe;

endmodule

// File: tb/tb_rmii_rx.sv
// tb_rmii_rx: directed and random RMII frames checked against a frame-level model.
// Expected pulses are derived from how each frame is built, not from RTL state.
module tb_rmii_rx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       crs_dv = 1'b0;
  logic [1:0] rxd = 2'd0;
  logic [7:0] received_byte;
  logic       byte_valid, data_valid, frame_error;

  rmii_rx dut (
    .clk(clk),
    .resetn(resetn),
    .crs_dv(crs_dv),
    .rxd(rxd),
    .received_byte(received_byte),
    .byte_valid(byte_valid),
    .data_valid(data_valid),
    .frame_error(frame_error)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, passed = 0, fails = 0;

  // observed events
  int         ob_cyc[$];
  logic [7:0] ob_byte[$];
  int         ob_rise[$], ob_fall[$], ob_fe[$];
  logic       pdv = 1'b0;

  always @(posedge clk) begin
    #1;
    if (byte_valid) begin
      ob_cyc.push_back(cyc);
      ob_byte.push_back(received_byte);
    end
    if (data_valid && !pdv) ob_rise.push_back(cyc);
    if (!data_valid && pdv) ob_fall.push_back(cyc);
    if (frame_error) ob_fe.push_back(cyc);
    pdv = data_valid;
  end

  // expected events
  int         ex_cyc[$];
  logic [7:0] ex_byte[$];
  int         ex_rise[$], ex_fall[$], ex_fe[$];

  typedef struct {
    logic       c;
    logic [1:0] d;
    int         k;   // 0 none, 1 preamble 01, 2 byte completes
    logic [7:0] b;
    int         fl;  // 0 none, 1 clean end, 2 malformed end
  } dib_t;

  typedef logic [7:0] bq_t[$];

  dib_t fq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    ob_cyc.delete(); ob_byte.delete();
    ob_rise.delete(); ob_fall.delete(); ob_fe.delete();
    ex_cyc.delete(); ex_byte.delete();
    ex_rise.delete(); ex_fall.delete(); ex_fe.delete();
  endtask

  task automatic drive(input logic c, input logic [1:0] d, output int e);
    @(negedge clk);
    crs_dv = c;
    rxd    = d;
    e      = cyc + 1;
  endtask

  task automatic add_raw(input logic c, input logic [1:0] d);
    dib_t x;
    x = '{c, d, 0, 8'h00, 0};
    fq.push_back(x);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add_raw(1'b0, 2'($urandom));
  endtask

  // Frame: n0 x 00, np x 01, 11, payload LSB-first, pp stray dibits.
  task automatic add_frame(input int n0, input int np, input bq_t pl,
                           input int pp, input bit tog);
    dib_t x;
    int   st;
    st = fq.size();
    for (int i = 0; i < n0; i++) add_raw(1'b1, 2'b00);
    for (int i = 1; i <= np; i++) begin
      x = '{1'b1, 2'b01, (i % 4 == 0) ? 1 : 0, 8'h55, 0};
      fq.push_back(x);
    end
    x = '{1'b1, 2'b11, 2, 8'hD5, 0};
    fq.push_back(x);
    foreach (pl[j])
      for (int i = 0; i < 4; i++) begin
        x = '{1'b1, 2'(pl[j] >> (2 * i)), (i == 3) ? 2 : 0, pl[j], 0};
        fq.push_back(x);
      end
    for (int i = 0; i < pp; i++) add_raw(1'b1, 2'($urandom));
    if (tog && fq.size() - st >= 8)
      for (int i = 0; i < 8; i++) fq[fq.size() - 8 + i].c = i[0];
    fq[fq.size() - 1].fl = (pp != 0) ? 2 : 1;
  endtask

  // byte_valid may not repeat back-to-back, so a clash slips one cycle
  task automatic exp_byte(input int c, input logic [7:0] b, output int co);
    co = c;
    if (ex_cyc.size() > 0 && ex_cyc[ex_cyc.size() - 1] >= co - 1)
      co = ex_cyc[ex_cyc.size() - 1] + 2;
    ex_cyc.push_back(co);
    ex_byte.push_back(b);
  endtask

  task automatic play();
    int e, co;
    bit fresh;
    fresh = 1'b1;
    foreach (fq[i]) begin
      drive(fq[i].c, fq[i].d, e);
`ifdef RMII_RX_PREAMBLE_EMIT_EN
      if (fq[i].k == 1) begin
        exp_byte(e + 2, 8'h55, co);
        if (fresh) ex_rise.push_back(co);
        fresh = 1'b0;
      end
`endif
      if (fq[i].k == 2) begin
        exp_byte(e + 2, fq[i].b, co);
        if (fresh) ex_rise.push_back(co);
        fresh = 1'b0;
      end
      if (fq[i].fl != 0) begin
        ex_fall.push_back(e + 3);
        if (fq[i].fl == 2) ex_fe.push_back(e + 3);
        fresh = 1'b1;
      end
    end
    fq.delete();
  endtask

  task automatic check(input string tag);
    chk({tag, ":npulse"}, ob_cyc.size(), ex_cyc.size());
    for (int i = 0; i < ob_cyc.size() && i < ex_cyc.size(); i++) begin
      chk($sformatf("%s:pcyc%0d", tag, i), ob_cyc[i], ex_cyc[i]);
      chk($sformatf("%s:pbyte%0d", tag, i), ob_byte[i], ex_byte[i]);
    end
    chk({tag, ":nrise"}, ob_rise.size(), ex_rise.size());
    for (int i = 0; i < ob_rise.size() && i < ex_rise.size(); i++)
      chk($sformatf("%s:rise%0d", tag, i), ob_rise[i], ex_rise[i]);
    chk({tag, ":nfall"}, ob_fall.size(), ex_fall.size());
    for (int i = 0; i < ob_fall.size() && i < ex_fall.size(); i++)
      chk($sformatf("%s:fall%0d", tag, i), ob_fall[i], ex_fall[i]);
    chk({tag, ":nferr"}, ob_fe.size(), ex_fe.size());
    for (int i = 0; i < ob_fe.size() && i < ex_fe.size(); i++)
      chk($sformatf("%s:ferr%0d", tag, i), ob_fe[i], ex_fe[i]);
    if (ex_byte.size() > 0)
      chk({tag, ":hold"}, received_byte, ex_byte[ex_byte.size() - 1]);
    chk({tag, ":dv_end"}, data_valid, 1'b0);
    clr();
  endtask

  initial begin
    int   e, n0, np, nb, pp;
    bit   tog;
    bq_t  pl;

    repeat (3) @(negedge clk);
    chk("rst:byte", received_byte, 8'h00);
    chk("rst:bv", byte_valid, 1'b0);
    chk("rst:dv", data_valid, 1'b0);
    chk("rst:fe", frame_error, 1'b0);
    resetn = 1'b1;
    clr();

    add_idle(4);
    add_frame(0, 31, '{8'h00, 8'h1A, 8'h2B}, 0, 1'b0);
    add_idle(6);
    play();
    check("basic");

    add_idle(3);
    add_frame(3, 30, '{8'hC7, 8'h19, 8'hE4}, 0, 1'b0);
    add_idle(6);
    play();
    check("misalign");

    add_idle(3);
    add_frame(0, 31, '{8'h3C, 8'hA5}, 0, 1'b1);
    add_idle(6);
    play();
    check("toggle");

    add_idle(3);
    add_frame(0, 31, '{8'h11}, 2, 1'b0);
    add_idle(6);
    play();
    check("partial");

    add_idle(3);
    add_frame(0, 15, '{8'h81, 8'h7E}, 0, 1'b0);
    add_idle(2);
    add_frame(0, 9, '{8'h42}, 1, 1'b0);
    add_idle(6);
    play();
    check("b2b");

    for (int r = 0; r < 10; r++) begin
      n0 = $urandom_range(0, 4);
      np = $urandom_range(1, 33);
      nb = $urandom_range(0, 4);
      pp = $urandom_range(0, 3);
      tog = (nb >= 2 && pp == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      pl.delete();
      for (int j = 0; j < nb; j++) pl.push_back(8'($urandom));
      add_idle($urandom_range(2, 5));
      add_frame(n0, np, pl, pp, tog);
      add_idle(6);
      play();
      check($sformatf("rnd%0d", r));
    end

    // reset in the middle of a payload with crs_dv held high
    add_idle(3);
    for (int i = 0; i < 31; i++) add_raw(1'b1, 2'b01);
    add_raw(1'b1, 2'b11);
    for (int i = 0; i < 6; i++) add_raw(1'b1, 2'($urandom));
    play();
    drive(1'b1, 2'($urandom), e);
    resetn = 1'b0;
    clr();
    drive(1'b1, 2'($urandom), e);
    drive(1'b1, 2'($urandom), e);
    chk("mrst:byte", received_byte, 8'h00);
    chk("mrst:bv", byte_valid, 1'b0);
    chk("mrst:dv", data_valid, 1'b0);
    chk("mrst:fe", frame_error, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) add_raw(1'b1, 2'b01);
    add_raw(1'b1, 2'b11);
    for (int i = 0; i < 12; i++) add_raw(1'b1, 2'($urandom));
    add_idle(6);
    play();
    chk("mrst:npulse", ob_cyc.size(), 0);
    chk("mrst:nrise", ob_rise.size(), 0);
    chk("mrst:nferr", ob_fe.size(), 0);
    clr();

    add_idle(2);
    add_frame(1, 31, '{8'h5A, 8'hF0}, 0, 1'b0);
    add_idle(6);
    play();
    check("recover");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
